mem32k_ctrl: RTL

// - Synchronous initiator for the 32Kx8 asynchronous SRAM (active-low CS/OE/WE, shared bidirectional IO).
// - Turns single-beat REQ/READY read and write requests from the hash core into correctly sequenced SRAM strobes.
// - Returns read data with an RVALID pulse and signals write completion with a WDONE pulse.
// - Sits between the message/state buffers of the sha256 datapath and the external SRAM pins.

---
 rtl/mem32k_ctrl_pkg.sv | 32 +++
 rtl/mem32k_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem32k_ctrl_pkg.sv
// Shared constants, FSM encoding and wait-counter helper for the 32Kx8
// asynchronous SRAM initiator.
package mem32k_ctrl_pkg;

  localparam int MEM_ADDR_W       = 15;
  localparam int MEM_DATA_W       = 8;
  localparam int CNT_W            = 8;
  localparam int RD_WAIT_CYC_DEF  = 2;
  localparam int WR_PULSE_CYC_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_SETUP = 3'd1,
    ST_RD_WAIT  = 3'd2,
    ST_WR_SETUP = 3'd3,
    ST_WR_PULSE = 3'd4,
    ST_WR_HOLD  = 3'd5,
    ST_TURN     = 3'd6
  } state_e;

  // Value loaded into the shared down-counter so a state lasts 'cyc' cycles.
  function automatic logic [CNT_W-1:0] cnt_load(input int cyc);
    logic [CNT_W-1:0] val;
    if (cyc <= 1) begin
      val = 8'd0;
    end else begin
      val = CNT_W'(cyc - 1);
    end
    return val;
  endfunction

endpackage

// File: rtl/mem32k_ctrl.sv
// Single-beat REQ/READY initiator for a 32Kx8 async SRAM. Every pin-side
// output is a flop so CS/OE/WE never glitch; one dead TURN cycle separates ops.
module mem32k_ctrl
  import mem32k_ctrl_pkg::*;
#(
  parameter int RD_WAIT_CYC  = RD_WAIT_CYC_DEF,
  parameter int WR_PULSE_CYC = WR_PULSE_CYC_DEF
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REQ,
  input  logic        WR,
  input  logic [14:0] ADDR,
  input  logic [7:0]  WDATA,
  output logic        READY,
  output logic [7:0]  RDATA,
  output logic        RVALID,
  output logic        WDONE,
  output logic [14:0] MEM_A,
  inout  wire  [7:0]  MEM_IO,
  output logic        MEM_CS_N,
  output logic        MEM_OE_N,
  output logic        MEM_WE_N
);

  state_e           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [14:0]      mem_a_q,  mem_a_d;
  logic [7:0]       wdata_q,  wdata_d;
  logic [7:0]       rdata_q,  rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             wdone_q,  wdone_d;
  logic             ready_q,  ready_d;
  logic             cs_n_q,   cs_n_d;
  logic             oe_n_q,   oe_n_d;
  logic             we_n_q,   we_n_d;
  logic             drv_en_q, drv_en_d;

  // Next-state and next-output logic for the SRAM sequencing FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mem_a_d  = mem_a_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    wdone_d  = 1'b0;
    ready_d  = ready_q;
    cs_n_d   = cs_n_q;
    oe_n_d   = oe_n_q;
    we_n_d   = we_n_q;
    drv_en_d = drv_en_q;

    case (state_q)
      ST_IDLE: begin
        if (REQ && ready_q) begin
          ready_d = 1'b0;
          mem_a_d = ADDR;
          wdata_d = WDATA;
          cs_n_d  = 1'b0;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          if (WR) begin
            state_d  = ST_WR_SETUP;
            drv_en_d = 1'b1;
          end else begin
            state_d  = ST_RD_SETUP;
            drv_en_d = 1'b0;
          end
        end else begin
          ready_d = 1'b1;
        end
      end

      ST_RD_SETUP: begin
        state_d = ST_RD_WAIT;
        oe_n_d  = 1'b0;
        cnt_d   = cnt_load(RD_WAIT_CYC);
      end

      // X/Z on the bus is deliberately captured unfiltered.
      ST_RD_WAIT: begin
        if (cnt_q == 8'd0) begin
          rdata_d  = MEM_IO;
          rvalid_d = 1'b1;
          cs_n_d   = 1'b1;
          oe_n_d   = 1'b1;
          state_d  = ST_TURN;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_WR_SETUP: begin
        state_d = ST_WR_PULSE;
        we_n_d  = 1'b0;
        cnt_d   = cnt_load(WR_PULSE_CYC);
      end

      ST_WR_PULSE: begin
        if (cnt_q == 8'd0) begin
          we_n_d  = 1'b1;
          state_d = ST_WR_HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      // Address and data stay put one cycle past the WE_N rising edge.
      ST_WR_HOLD: begin
        cs_n_d   = 1'b1;
        drv_en_d = 1'b0;
        wdone_d  = 1'b1;
        state_d  = ST_TURN;
      end

      ST_TURN: begin
        cs_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        drv_en_d = 1'b0;
        ready_d  = 1'b1;
        state_d  = ST_IDLE;
      end

      default: begin
        cs_n_d   = 1'b1;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        drv_en_d = 1'b0;
        ready_d  = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset parks every strobe inactive at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 8'd0;
      mem_a_q  <= 15'd0;
      wdata_q  <= 8'd0;
      rdata_q  <= 8'd0;
      rvalid_q <= 1'b0;
      wdone_q  <= 1'b0;
      ready_q  <= 1'b1;
      cs_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      drv_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mem_a_q  <= mem_a_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      wdone_q  <= wdone_d;
      ready_q  <= ready_d;
      cs_n_q   <= cs_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      drv_en_q <= drv_en_d;
    end
  end

  assign MEM_IO   = drv_en_q ? wdata_q : 8'bz;
  assign READY    = ready_q;
  assign RDATA    = rdata_q;
  assign RVALID   = rvalid_q;
  assign WDONE    = wdone_q;
  assign MEM_A    = mem_a_q;
  assign MEM_CS_N = cs_n_q;
  assign MEM_OE_N = oe_n_q;
  assign MEM_WE_N = we_n_q;

endmodule
